// File: rtl/cond_pkg.sv
// cond_pkg: shared definitions for the conditional-execution block.
//   - 4-bit ARM condition code constants
//   - bit positions of N, Z, C, V inside the 4-bit flag vector
//   - flag group indices (NZ group / CV group) used for FlagW and flag enables
package cond_pkg;

  // ARM condition codes
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Flag bit positions in {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Flag groups: bit 1 of FlagW covers N,Z; bit 0 covers C,V
  localparam int GRP_NZ = 1;
  localparam int GRP_CV = 0;

  // The "else" slot of an IT block uses the base condition with bit 0 flipped
  function automatic logic [3:0] invert_cond(input logic [3:0] cond);
    return {cond[3:1], ~cond[0]};
  endfunction

endpackage

// File: rtl/cond_eval.sv
// cond_eval: purely combinational ARM condition check.
// Ports:
//   cond  [3:0]  condition code to evaluate
//   flags [3:0]  {N,Z,C,V}
//   pass         1 when the condition holds for the given flags
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n_s, z_s, c_s, v_s;

  assign n_s = flags[FLAG_N];
  assign z_s = flags[FLAG_Z];
  assign c_s = flags[FLAG_C];
  assign v_s = flags[FLAG_V];

  // Decode the condition code against the current flags
  always_comb begin
    pass = 1'b1;
    case (cond)
      COND_EQ: pass = z_s;
      COND_NE: pass = ~z_s;
      COND_CS: pass = c_s;
      COND_CC: pass = ~c_s;
      COND_MI: pass = n_s;
      COND_PL: pass = ~n_s;
      COND_VS: pass = v_s;
      COND_VC: pass = ~v_s;
      COND_HI: pass = c_s & ~z_s;
      COND_LS: pass = ~c_s | z_s;
      COND_GE: pass = (n_s == v_s);
      COND_LT: pass = (n_s != v_s);
      COND_GT: pass = ~z_s & (n_s == v_s);
      COND_LE: pass = z_s | (n_s != v_s);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b1;
      default: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/flopenr.sv
// flopenr: resettable flop with load enable (asynchronous active-high reset).
// Ports:
//   clk, reset   clock / async reset (clears q to 0)
//   en           load d on the rising edge when set
//   d, q         WIDTH-bit data in / registered data out
module flopenr #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Storage with async clear and synchronous load enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/condlogic_it.sv
// condlogic_it: condition logic for a multicycle ARM-style core with
// IT (if-then) predication blocks.
// Ports:
//   clk, reset                 clock / asynchronous active-high reset
//   Cond [3:0]                 condition field of the current instruction
//   ALUFlags [3:0]             {N,Z,C,V} produced by the ALU
//   FlagW [1:0]                bit1 writes N,Z; bit0 writes C,V
//   PCS, NextPC, RegW, MemW    write requests from decoder / control FSM
//   InstrDone                  one-cycle pulse when an instruction retires
//   ITStart, ITLen, ITMask,    load a predication block: length, per-slot
//   ITCond                     then/else bits (slot 0 = LSB), base condition
//   PCWrite, RegWrite,         write enables gated by the condition
//   MemWrite
//   CondEx                     effective condition passed
//   Flags [3:0]                architectural {N,Z,C,V}
//   ITActive                   predication block in progress
module condlogic_it
  import cond_pkg::*;
#(
  parameter int ITDEPTH   = 4,
  parameter int FLAGDELAY = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         Cond,
  input  logic [3:0]         ALUFlags,
  input  logic [1:0]         FlagW,
  input  logic               PCS,
  input  logic               NextPC,
  input  logic               RegW,
  input  logic               MemW,
  input  logic               InstrDone,
  input  logic               ITStart,
  input  logic [3:0]         ITLen,
  input  logic [ITDEPTH-1:0] ITMask,
  input  logic [3:0]         ITCond,
  output logic               PCWrite,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               CondEx,
  output logic [3:0]         Flags,
  output logic               ITActive
);

  localparam logic [3:0] DEPTH_L = 4'(ITDEPTH);

  // IT block state. The mask is widened to 8 entries so the 3-bit slot
  // index always addresses a real bit, whatever ITDEPTH is.
  logic [3:0] count_q, count_d;
  logic [2:0] slot_q,  slot_d;
  logic [7:0] mask_q,  mask_d;
  logic [3:0] cond_q,  cond_d;

  logic [3:0] len_s;
  logic [3:0] eff_cond_s;
  logic [1:0] flag_en_s;

  assign ITActive = (count_q != 4'd0);

  // Clamp requested block length to the supported depth
  always_comb begin
    if (ITLen > DEPTH_L) begin
      len_s = DEPTH_L;
    end else begin
      len_s = ITLen;
    end
  end

  // Effective condition: instruction field outside a block, block condition
  // (possibly inverted for an "else" slot) inside it
  always_comb begin
    if (ITActive) begin
      if (mask_q[slot_q]) begin
        eff_cond_s = cond_q;
      end else begin
        eff_cond_s = invert_cond(cond_q);
      end
    end else begin
      eff_cond_s = Cond;
    end
  end

  cond_eval u_cond_eval (
    .cond  (eff_cond_s),
    .flags (Flags),
    .pass  (CondEx)
  );

  assign RegWrite = RegW & CondEx;
  assign MemWrite = MemW & CondEx;
  assign PCWrite  = (PCS & CondEx) | NextPC;

  // IT next state: a new block load overrides retirement; a taken branch
  // ends the block; a failed instruction still consumes its slot
  always_comb begin
    count_d = count_q;
    slot_d  = slot_q;
    mask_d  = mask_q;
    cond_d  = cond_q;
    if (ITStart && (len_s != 4'd0)) begin
      count_d = len_s;
      slot_d  = 3'd0;
      mask_d  = 8'(ITMask);
      cond_d  = ITCond;
    end else if (InstrDone && ITActive) begin
      if (PCS && CondEx) begin
        count_d = 4'd0;
      end else begin
        count_d = count_q - 4'd1;
      end
      slot_d = slot_q + 3'd1;
    end else begin
      count_d = count_q;
    end
  end

  // IT state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 4'd0;
      slot_q  <= 3'd0;
      mask_q  <= 8'd0;
      cond_q  <= 4'd0;
    end else begin
      count_q <= count_d;
      slot_q  <= slot_d;
      mask_q  <= mask_d;
      cond_q  <= cond_d;
    end
  end

  generate
    if (FLAGDELAY != 0) begin : g_flag_delay
      // The ALU result arrives one cycle after the condition is known
      logic [1:0] flag_write_q, flag_write_d;

      assign flag_write_d = FlagW & {2{CondEx}};

      // Deferred flag-write enables
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          flag_write_q <= 2'b00;
        end else begin
          flag_write_q <= flag_write_d;
        end
      end

      assign flag_en_s = flag_write_q;
    end else begin : g_flag_direct
      assign flag_en_s = FlagW & {2{CondEx}};
    end
  endgenerate

  flopenr #(.WIDTH(2)) u_flags_nz (
    .clk   (clk),
    .reset (reset),
    .en    (flag_en_s[GRP_NZ]),
    .d     (ALUFlags[3:2]),
    .q     (Flags[3:2])
  );

  flopenr #(.WIDTH(2)) u_flags_cv (
    .clk   (clk),
    .reset (reset),
    .en    (flag_en_s[GRP_CV]),
    .d     (ALUFlags[1:0]),
    .q     (Flags[1:0])
  );

endmodule

// File: tb/tb_condlogic_it.sv
// tb_condlogic_it: directed scenarios plus randomized traffic, checked
// against an abstract reference model of flags and predication blocks.
module tb_condlogic_it;

  logic       clk;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, NextPC, RegW, MemW;
  logic       InstrDone, ITStart;
  logic [3:0] ITLen;
  logic [3:0] ITMask;
  logic [3:0] ITCond;
  logic       PCWrite, RegWrite, MemWrite, CondEx, ITActive;
  logic [3:0] Flags;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [3:0] m_flags;
  logic [1:0] m_fw;
  int         m_count;
  int         m_slot;
  logic [7:0] m_mask;
  logic [3:0] m_cond;

  condlogic_it #(.ITDEPTH(4), .FLAGDELAY(1)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .InstrDone(InstrDone), .ITStart(ITStart), .ITLen(ITLen), .ITMask(ITMask),
    .ITCond(ITCond), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .CondEx(CondEx), .Flags(Flags), .ITActive(ITActive)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Condition check by family: codes pair up as (test, negated test)
  function automatic bit ref_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, r;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c[3:1] != 3'd7 && c[0]) r = !r;
    return r;
  endfunction

  function automatic logic [3:0] model_eff();
    if (m_count == 0) return Cond;
    if (m_mask[m_slot]) return m_cond;
    return m_cond ^ 4'b0001;
  endfunction

  task automatic model_reset();
    m_flags = 4'd0; m_fw = 2'd0; m_count = 0; m_slot = 0;
    m_mask = 8'd0; m_cond = 4'd0;
  endtask

  // Compare DUT to model for this cycle, advance model across the edge,
  // then return at the following falling edge
  task automatic tick();
    bit ce;
    int len;
    if (reset) model_reset();
    #1;
    ce = ref_pass(model_eff(), m_flags);
    check_val("condex",   {31'd0, CondEx},   {31'd0, ce});
    check_val("regwrite", {31'd0, RegWrite}, {31'd0, RegW & ce});
    check_val("memwrite", {31'd0, MemWrite}, {31'd0, MemW & ce});
    check_val("pcwrite",  {31'd0, PCWrite},  {31'd0, (PCS & ce) | NextPC});
    check_val("flags",    {28'd0, Flags},    {28'd0, m_flags});
    check_val("itactive", {31'd0, ITActive}, {31'd0, m_count != 0});
    if (!reset) begin
      if (m_fw[1]) m_flags[3:2] = ALUFlags[3:2];
      if (m_fw[0]) m_flags[1:0] = ALUFlags[1:0];
      m_fw = FlagW & {ce, ce};
      len = (ITLen > 4) ? 4 : int'(ITLen);
      if (ITStart && len > 0) begin
        m_count = len; m_slot = 0; m_mask = {4'd0, ITMask}; m_cond = ITCond;
      end else if (InstrDone && m_count != 0) begin
        m_count = (PCS && ce) ? 0 : m_count - 1;
        m_slot  = m_slot + 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    Cond = 4'd0; ALUFlags = 4'd0; FlagW = 2'd0; PCS = 1'b0; NextPC = 1'b0;
    RegW = 1'b0; MemW = 1'b0; InstrDone = 1'b0; ITStart = 1'b0;
    ITLen = 4'd0; ITMask = 4'd0; ITCond = 4'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Load flags through the delayed write path (two cycles)
  task automatic load_flags(input logic [3:0] val);
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = val;
    tick();
    FlagW = 2'b00;
    tick();
  endtask

  initial begin
    clear_inputs();
    model_reset();
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_val("rst_flags",    {28'd0, Flags},  32'd0);
    check_val("rst_itactive", {31'd0, ITActive}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Flag write through delayed path, then EQ sees Z
    Cond = 4'b0000;
    #1 check_val("eq_flags0", {31'd0, CondEx}, 32'd0);
    tick();
    Cond = 4'b1110; FlagW = 2'b10; ALUFlags = 4'b0100;
    tick();
    FlagW = 2'b00;
    #1 check_val("flag_not_yet", {28'd0, Flags}, 32'd0);
    tick();
    Cond = 4'b0000;
    #1 check_val("flags_0100", {28'd0, Flags}, 32'h4);
    check_val("eq_after_z", {31'd0, CondEx}, 32'd1);
    tick();

    // Failed LT blocks flag and register writes
    do_reset();
    Cond = 4'b1011; FlagW = 2'b11; ALUFlags = 4'b1111; RegW = 1'b1;
    #1 check_val("lt_condex", {31'd0, CondEx}, 32'd0);
    check_val("lt_regwrite", {31'd0, RegWrite}, 32'd0);
    tick();
    FlagW = 2'b00;
    tick();
    check_val("lt_flags", {28'd0, Flags}, 32'd0);
    RegW = 1'b0;

    // IT block, mask 0101 on EQ with Z=1 -> 1,0,1
    load_flags(4'b0100);
    ITStart = 1'b1; ITLen = 4'd3; ITMask = 4'b0101; ITCond = 4'b0000;
    Cond = 4'b0001;
    tick();
    ITStart = 1'b0; InstrDone = 1'b1;
    #1 check_val("it_slot0", {31'd0, CondEx}, 32'd1);
    tick();
    #1 check_val("it_slot1", {31'd0, CondEx}, 32'd0);
    tick();
    #1 check_val("it_slot2", {31'd0, CondEx}, 32'd1);
    check_val("it_active2", {31'd0, ITActive}, 32'd1);
    tick();
    InstrDone = 1'b0;
    #1 check_val("it_done", {31'd0, ITActive}, 32'd0);
    tick();

    // Length clamp and zero-length ignore
    ITStart = 1'b1; ITLen = 4'd12; ITMask = 4'b0000; ITCond = 4'b1110;
    tick();
    ITStart = 1'b0; InstrDone = 1'b1;
    tick(); tick(); tick();
    #1 check_val("clamp_active3", {31'd0, ITActive}, 32'd1);
    tick();
    InstrDone = 1'b0;
    #1 check_val("clamp_done4", {31'd0, ITActive}, 32'd0);
    ITStart = 1'b1; ITLen = 4'd0;
    tick();
    ITStart = 1'b0;
    #1 check_val("len0_ignored", {31'd0, ITActive}, 32'd0);
    tick();

    // Taken branch in slot 1 ends the block; NextPC ignores CondEx
    ITStart = 1'b1; ITLen = 4'd4; ITMask = 4'b1111; ITCond = 4'b1110;
    tick();
    ITStart = 1'b0; InstrDone = 1'b1;
    tick();
    PCS = 1'b1;
    #1 check_val("br_pcwrite", {31'd0, PCWrite}, 32'd1);
    tick();
    PCS = 1'b0; InstrDone = 1'b0;
    #1 check_val("br_ends_block", {31'd0, ITActive}, 32'd0);
    NextPC = 1'b1; Cond = 4'b0001;
    #1 check_val("nextpc_ce", {31'd0, CondEx}, 32'd0);
    check_val("nextpc_pcw", {31'd0, PCWrite}, 32'd1);
    tick();
    NextPC = 1'b0;

    // Asynchronous reset mid-block
    load_flags(4'b1010);
    ITStart = 1'b1; ITLen = 4'd4; ITMask = 4'b1111; ITCond = 4'b1110;
    tick();
    ITStart = 1'b0;
    #2 reset = 1'b1;
    #1 check_val("async_flags", {28'd0, Flags}, 32'd0);
    check_val("async_itactive", {31'd0, ITActive}, 32'd0);
    tick();
    reset = 1'b0;
    Cond = 4'b0000;
    #1 check_val("post_rst_cond", {31'd0, CondEx}, 32'd0);
    tick();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 63) == 0);
      Cond      = 4'($urandom_range(0, 15));
      ALUFlags  = 4'($urandom_range(0, 15));
      FlagW     = 2'($urandom_range(0, 3));
      PCS       = ($urandom_range(0, 5) == 0);
      NextPC    = ($urandom_range(0, 7) == 0);
      RegW      = 1'($urandom_range(0, 1));
      MemW      = 1'($urandom_range(0, 1));
      InstrDone = ($urandom_range(0, 2) == 0);
      ITStart   = ($urandom_range(0, 5) == 0);
      ITLen     = 4'($urandom_range(0, 15));
      ITMask    = 4'($urandom_range(0, 15));
      ITCond    = 4'($urandom_range(0, 15));
      tick();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
